// File: rtl/s4_preimage_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// s4_preimage_gen : streams every 6-bit DES S4 input mapping to a target nibble
// Rev 1.0
// ---------------------------------------------------------------------------
module s4_preimage_gen #(
  parameter logic [3:0] ROW_MASK = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_target,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_data,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_EMIT   = 2'd2
  } state_t;

  // Forward S4 table, {row3,row2,row1,row0}; each row packs column 15 in its top nibble.
  localparam logic [255:0] C_S4 = {
    64'hE27C_B549_8D1A_60F3,
    64'h4825_E31F_D7BC_096A,
    64'h9EA1_C274_30F6_5B8D,
    64'hF4CB_5821_A960_3ED7
  };

  state_t      state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [3:0]  target_q, target_d;
  logic [5:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic [3:0]  w_s4_val;

  function automatic logic [1:0] first_row();
    logic [1:0] fr;
    fr = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ROW_MASK[i[1:0]]) fr = i[1:0];
    end
    return fr;
  endfunction

  function automatic logic [1:0] next_row(input logic [1:0] r);
    logic [1:0] nr;
    nr = r;
    for (int i = 3; i >= 0; i--) begin
      if (ROW_MASK[i[1:0]] && (i > int'(r))) nr = i[1:0];
    end
    return nr;
  endfunction

  function automatic logic has_higher(input logic [1:0] r);
    logic h;
    h = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ROW_MASK[i[1:0]] && (i > int'(r))) h = 1'b1;
    end
    return h;
  endfunction

  assign w_s4_val = C_S4[{row_q, col_q, 2'b00} +: 4];

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    target_d    = target_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          target_d = in_target;
          col_d    = 4'd0;
          row_d    = first_row();
          state_d  = S_SEARCH;
        end
      end
      S_SEARCH: begin
        // Each row is a permutation, so a match arrives no later than column 15.
        if (w_s4_val == target_q) begin
          out_data_d  = {row_q[1], col_q, row_q[0]};
          out_valid_d = 1'b1;
          out_last_d  = ~has_higher(row_q);
          state_d     = S_EMIT;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = S_IDLE;
          end else begin
            row_d   = next_row(row_q);
            col_d   = 4'd0;
            state_d = S_SEARCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= 2'd0;
      col_q       <= 4'd0;
      target_q    <= 4'd0;
      out_data_q  <= 6'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      target_q    <= target_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire
